// File: rtl/fifo_almost_full_status.sv
// First-word fall-through FIFO with early almost-full warning,
// almost-empty flag, occupancy count and sticky overflow flag.
module fifo_almost_full_status #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 5,
    parameter int DEPTH              = 32,
    parameter int GRACE_PERIOD       = 2,
    parameter int ALMOST_EMPTY_LEVEL = 1,
    parameter     MEM_STYLE          = "auto"
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_empty_n,
    output logic                  if_overflow
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH =
        (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_WARN =
        (ADDR_WIDTH+1)'(DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH:0] LP_AE =
        (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST =
        ADDR_WIDTH'(DEPTH - 1);

    // The storage hint is for implementation tools only.
    if (MEM_STYLE == "") begin : g_no_mem_hint
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  r_aempty_n;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_rest;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_rptr_nxt;
    logic [ADDR_WIDTH-1:0] w_wptr_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;

    function automatic logic [ADDR_WIDTH-1:0] f_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == LP_LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Accept/drop decisions, next occupancy and next head word.
    always_comb begin
        w_push = if_write & if_write_ce & (r_count < LP_DEPTH);
        w_drop = if_write & if_write_ce & (r_count == LP_DEPTH);
        w_pop  = if_read & if_read_ce & r_empty_n;
        w_rest = r_count - (ADDR_WIDTH+1)'(w_pop);
        w_count_nxt = w_rest + (ADDR_WIDTH+1)'(w_push);
        w_rptr_nxt  = w_pop  ? f_inc(r_rptr) : r_rptr;
        w_wptr_nxt  = w_push ? f_inc(r_wptr) : r_wptr;
        // With nothing left after the pop, the incoming word
        // becomes the head directly; otherwise read it from storage.
        if (w_rest == '0) begin
            w_dout_nxt = w_push ? if_din : r_dout;
        end else begin
            w_dout_nxt = r_mem[w_rptr_nxt];
        end
    end

    // Storage write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= if_din;
        end
    end

    // Pointers, occupancy, head register and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_empty_n  <= 1'b0;
            r_full_n   <= 1'b1;
            r_aempty_n <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_dout     <= w_dout_nxt;
            r_empty_n  <= (w_count_nxt != '0);
            r_full_n   <= (w_count_nxt < LP_WARN);
            r_aempty_n <= (w_count_nxt > LP_AE);
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign if_full_n         = r_full_n;
    assign if_empty_n        = r_empty_n;
    assign if_dout           = r_dout;
    assign if_count          = r_count;
    assign if_almost_empty_n = r_aempty_n;
    assign if_overflow       = r_overflow;

endmodule

// File: tb/tb_fifo_almost_full_status.sv
// Randomized self-checking bench for fifo_almost_full_status
// against a queue-based reference model.
module tb_fifo_almost_full_status;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int GRACE = 2;
    localparam int AEL = 1;

    logic          clk;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_empty_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_count;
    logic          if_almost_empty_n;
    logic          if_overflow;

    fifo_almost_full_status #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .GRACE_PERIOD(GRACE),
        .ALMOST_EMPTY_LEVEL(AEL),
        .MEM_STYLE("auto")
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_full_n(if_full_n),
        .if_write_ce(if_write_ce),
        .if_write(if_write),
        .if_din(if_din),
        .if_empty_n(if_empty_n),
        .if_read_ce(if_read_ce),
        .if_read(if_read),
        .if_dout(if_dout),
        .if_count(if_count),
        .if_almost_empty_n(if_almost_empty_n),
        .if_overflow(if_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_q [$];
    bit            m_ovf;

    function automatic logic [4:0] m_flags();
        int n;
        n = m_q.size();
        return {(n > 0), (n < DEPTH - GRACE), (n > AEL), m_ovf,
                1'b0};
    endfunction

    // Drive one cycle of inputs and advance the model on the edge.
    task automatic step(input bit w, input bit wce,
                        input logic [DW-1:0] d, input bit r,
                        input bit rce, input bit rst);
        bit full;
        bit pop;
        reset = rst;
        if_write = w;
        if_write_ce = wce;
        if_din = d;
        if_read = r;
        if_read_ce = rce;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop = r && rce && (m_q.size() > 0);
            if (w && wce && full) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (w && wce && !full) m_q.push_back(d);
        end
        #1;
        reset = 1'b0;
        if_write = 1'b0;
        if_read = 1'b0;
    endtask

    task automatic test_reset();
        step(0, 1, 0, 0, 1, 1);
        n_cmp++;
        if (if_count !== 0 || if_empty_n !== 0 || if_full_n !== 1 ||
            if_almost_empty_n !== 0 || if_overflow !== 0) begin
            n_err++;
            $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b o=%b want 0 0 1 0 0",
                     if_count, if_empty_n, if_full_n,
                     if_almost_empty_n, if_overflow);
        end
        n_cmp++;
        if (if_dout !== 0) begin
            n_err++;
            $display("FAIL reset_dout: got %h want 00", if_dout);
        end
    endtask

    task automatic test_single_write();
        step(1, 1, 8'hA1, 0, 1, 0);
        n_cmp++;
        if (if_empty_n !== 1 || if_dout !== 8'hA1 ||
            if_count !== 1 || if_almost_empty_n !== 0) begin
            n_err++;
            $display("FAIL single_write: e=%b d=%h c=%0d ae=%b want 1 a1 1 0",
                     if_empty_n, if_dout, if_count, if_almost_empty_n);
        end
        step(0, 1, 0, 1, 1, 0);
        n_cmp++;
        if (if_count !== 0 || if_empty_n !== 0) begin
            n_err++;
            $display("FAIL single_pop: c=%0d e=%b want 0 0",
                     if_count, if_empty_n);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, DW'($urandom), 0, 1, 0);
            n_cmp++;
            if (if_count !== (AW+1)'(i + 1) ||
                if_full_n !== (i + 1 < DEPTH - GRACE)) begin
                n_err++;
                $display("FAIL fill_%0d: c=%0d f=%b want %0d %b", i,
                         if_count, if_full_n, i + 1,
                         (i + 1 < DEPTH - GRACE));
            end
        end
        n_cmp++;
        if (if_overflow !== 0 || if_dout !== m_q[0]) begin
            n_err++;
            $display("FAIL fill_end: o=%b d=%h want 0 %h",
                     if_overflow, if_dout, m_q[0]);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] head;
        head = m_q[0];
        step(1, 1, 8'h5A, 0, 1, 0);
        n_cmp++;
        if (if_overflow !== 1 || if_count !== 8 || if_dout !== head) begin
            n_err++;
            $display("FAIL ovf_drop: o=%b c=%0d d=%h want 1 8 %h",
                     if_overflow, if_count, if_dout, head);
        end
        step(1, 1, 8'h5B, 1, 1, 0);
        n_cmp++;
        if (if_overflow !== 1 || if_count !== 7) begin
            n_err++;
            $display("FAIL ovf_drop_pop: o=%b c=%0d want 1 7",
                     if_overflow, if_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_q.size() > 0) begin
                n_cmp++;
                if (if_empty_n !== 1 || if_dout !== m_q[0]) begin
                    n_err++;
                    $display("FAIL ovf_read_%0d: e=%b d=%h want 1 %h",
                             i, if_empty_n, if_dout, m_q[0]);
                end
                step(0, 1, 0, 1, 1, 0);
            end
        end
        n_cmp++;
        if (if_count !== 0 || if_empty_n !== 0 || if_overflow !== 1) begin
            n_err++;
            $display("FAIL ovf_sticky: c=%0d e=%b o=%b want 0 0 1",
                     if_count, if_empty_n, if_overflow);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, DW'($urandom), 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, DW'($urandom), 1, 1, 0);
            n_cmp++;
            if (if_count !== 3 || if_dout !== m_q[0]) begin
                n_err++;
                $display("FAIL b2b_%0d: c=%0d d=%h want 3 %h", i,
                         if_count, if_dout, m_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (m_q.size() < 5) step(1, 1, DW'($urandom), 0, 1, 0);
        step(1, 1, 8'hEE, 1, 1, 1);
        n_cmp++;
        if (if_count !== 0 || if_empty_n !== 0 || if_full_n !== 1 ||
            if_almost_empty_n !== 0 || if_overflow !== 0 ||
            if_dout !== 0) begin
            n_err++;
            $display("FAIL reset_mid: c=%0d e=%b f=%b ae=%b o=%b d=%h",
                     if_count, if_empty_n, if_full_n,
                     if_almost_empty_n, if_overflow, if_dout);
        end
    endtask

    task automatic test_ce();
        step(1, 1, 8'h11, 0, 1, 0);
        step(1, 1, 8'h22, 0, 1, 0);
        step(1, 0, 8'h33, 1, 0, 0);
        n_cmp++;
        if (if_count !== 2 || if_dout !== 8'h11) begin
            n_err++;
            $display("FAIL ce_gate: c=%0d d=%h want 2 11",
                     if_count, if_dout);
        end
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        n_cmp++;
        if (if_count !== 0 || if_empty_n !== 0 || if_overflow !== 0) begin
            n_err++;
            $display("FAIL read_empty: c=%0d e=%b o=%b want 0 0 0",
                     if_count, if_empty_n, if_overflow);
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7) != 0,
                 DW'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
            got = {if_empty_n, if_full_n, if_almost_empty_n,
                   if_overflow, 1'b0};
            n_cmp++;
            if (if_count !== (AW+1)'(m_q.size()) || got !== m_flags()) begin
                n_err++;
                $display("FAIL rand_state_%0d: c=%0d fl=%b want %0d %b",
                         i, if_count, got, m_q.size(), m_flags());
            end
            if (m_q.size() > 0) begin
                n_cmp++;
                if (if_dout !== m_q[0]) begin
                    n_err++;
                    $display("FAIL rand_dout_%0d: got %h want %h",
                             i, if_dout, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        if_write = 1'b0;
        if_write_ce = 1'b0;
        if_din = '0;
        if_read = 1'b0;
        if_read_ce = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_ce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
